dht_sensor_reader_param: RTL and testbench
==========================================

// Module: dht_sensor_reader_param
// PURPOSE
// - Parametrised single-wire (DHT11/DHT22-class) sensor reader: issues start pulse, decodes NUM_BITS pulse-width bits, optionally verifies checksum, retries on failure.
// - Runs on the system clock with an internal 1 us tick enable (no derived clock); bus pin split into sensor_in / sensor_drive_low for the top-level open-drain buffer.
// - Sits between the UART command decoder and the sensor pin.
// PARAMETERS
// CLK_FREQ_HZ      50_000_000  system clock frequency; tick period = CLK_FREQ_HZ/1_000_000 cycles (must divide exactly)
// NUM_BITS         40          frame length in bits (multiple of 8, >=16)
// START_LOW_US     19000       host start pulse low time
// RELEASE_US       20          host release time before sampling response
// BIT_THRESH_US    50          high time > BIT_THRESH_US decodes '1', else '0'
// TIMEOUT_US       65000       max wait for any single bus edge
// GUARD_US         2000        bus idle time between retry attempts
// MAX_RETRIES      2           extra attempts after first failure (0..7)
// PORTS
// clock             in   1          system clock
// reset             in   1          asynchronous, active-high reset
// start             in   1          1-cycle request; ignored while busy
// sensor_in         in   1          raw bus level (asynchronous)
// sensor_drive_low  out  1          1 = pull bus low, 0 = release (pull-up)
// busy              out  1          high from accepted start until done
// done              out  1          1-cycle pulse, transaction finished (success or final failure)
// error             out  1          valid with done; held until next accepted start
// error_code        out  2          0 none, 1 no response, 2 frame timeout, 3 checksum mismatch
// attempts          out  3          attempts used in last transaction (1..MAX_RETRIES+1)
// data              out  NUM_BITS   last good frame, MSB first received; updated only on success
// BEHAVIOUR
// - Reset: sensor_drive_low=0, busy=0, done=0, error=0, error_code=0, attempts=0, data=0, FSM=IDLE, tick/timers cleared.
// - sensor_in passes a 2-flop synchroniser; all decisions use synchronised level (2-cycle latency).
// - Tick: free-running divider, 1-cycle enable every CLK_FREQ_HZ/1e6 clocks; us counter 17 bits, increments on tick, cleared on every state change.
// - FSM:
//   IDLE: start=1 -> busy=1, attempts=1, error/error_code cleared, -> START_LOW.
//   START_LOW: drive_low=1; us==START_LOW_US -> RELEASE.
//   RELEASE: drive_low=0; us==RELEASE_US -> RESP_LOW.
//   RESP_LOW: wait bus 0 -> RESP_HIGH.
//   RESP_HIGH: wait bus 1 -> RESP_END.
//   RESP_END: wait bus 0 -> BIT_LOW.
//   BIT_LOW: wait bus 1 -> BIT_HIGH.
//   BIT_HIGH: wait bus 0; shift in (us > BIT_THRESH_US); after NUM_BITS-th bit -> CHECK, else BIT_LOW.
//   CHECK: one cycle; pass -> DONE ok; fail -> code 3, FAIL.
//   FAIL: attempts <= MAX_RETRIES -> GUARD; else DONE with error=1.
//   GUARD: drive_low=0; us==GUARD_US -> attempts+1, START_LOW.
//   DONE: done=1 one cycle, busy=0 same cycle, -> IDLE.
// - Timeout: us==TIMEOUT_US in RESP_LOW/RESP_HIGH -> code 1; in RESP_END/BIT_LOW/BIT_HIGH -> code 2; both -> FAIL.
// - Shift register cleared on every START_LOW entry; data loaded from it only on success, same cycle as done.
// - error_code reflects most recent failure; on final success after retries error=0, error_code=0.
// - start while busy ignored (no queueing); start in same cycle as done ignored.
// - reset mid-transaction: bus released immediately (async), all outputs to reset values.
// CONFIGURATION
// - CHECKSUM_VERIFY_EN defined: CHECK compares last byte with (sum of preceding NUM_BITS/8-1 bytes) mod 256; mismatch -> code 3 + retry path.
// - CHECKSUM_VERIFY_EN undefined: CHECK always passes; code 3 never produced.
// TESTING
// - Model DHT11 (80/80 us response, 50 us low, 26 us '0'/70 us '1'), frame 0x23_00_19_00_3C, start -> done after one attempt, data=0x230019003C, error=0, attempts=1.
// - Bus held high (no sensor), MAX_RETRIES=2 -> 3 start pulses separated by GUARD_US, done with error=1, code=1, attempts=3, data unchanged.
// - Model stops after bit 17 -> code 2 on attempt 1; good frame on attempt 2 -> error=0, attempts=2, data updated.
// - CHECKSUM_VERIFY_EN, frame 0x23_00_19_00_3D always -> error=1, code=3, attempts=3; undefined -> success, data=0x230019003D.
// - Assert reset 5 ms into START_LOW -> sensor_drive_low=0 and busy=0 within same cycle; next start runs full 19 ms pulse.
// - start pulsed while busy and at done cycle -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/dht_sensor_reader_param_if.sv
// ---------------------------------------------------------------------------
// dht_sensor_reader_param_if
// Bundle between the single-wire sensor reader and its surroundings: the
// command side that requests a read and collects the result, and the pin
// side (open-drain buffer) that carries the raw bus level in and the
// pull-low request out.
//
// Signals
//   start             request a read, 1-cycle pulse (ignored while busy)
//   sensor_in         raw bus level from the pad (asynchronous)
//   sensor_drive_low  1 = pull bus low, 0 = release to the pull-up
//   busy              transaction in progress
//   done              1-cycle pulse when a transaction finishes
//   error             final failure flag, valid with done, held until next start
//   error_code        0 none, 1 no response, 2 frame timeout, 3 checksum mismatch
//   attempts          attempts used by the last transaction
//   data              last good frame, first received bit in the MSB
//
// Modports
//   master : command decoder / pad side (drives start and sensor_in)
//   slave  : the reader itself
// ---------------------------------------------------------------------------
interface dht_sensor_reader_param_if #(
    parameter int NUM_BITS = 40
);
    logic                start;
    logic                sensor_in;
    logic                sensor_drive_low;
    logic                busy;
    logic                done;
    logic                error;
    logic [1:0]          error_code;
    logic [2:0]          attempts;
    logic [NUM_BITS-1:0] data;

    modport master (
        output start,
        output sensor_in,
        input  sensor_drive_low,
        input  busy,
        input  done,
        input  error,
        input  error_code,
        input  attempts,
        input  data
    );

    modport slave (
        input  start,
        input  sensor_in,
        output sensor_drive_low,
        output busy,
        output done,
        output error,
        output error_code,
        output attempts,
        output data
    );
endinterface

// File: rtl/dht_sensor_reader_param.sv
// ---------------------------------------------------------------------------
// dht_sensor_reader_param
// Single-wire (DHT11/DHT22-class) sensor reader. On start it pulls the bus
// low for START_LOW_US, releases it, follows the sensor's response preamble
// and then decodes NUM_BITS pulse-width coded bits (high time longer than
// BIT_THRESH_US is a '1'). Any bus edge that does not arrive within
// TIMEOUT_US fails the attempt; failed attempts are retried up to
// MAX_RETRIES times with GUARD_US of idle bus in between.
//
// Timing is derived from a 1 us tick enable generated from the system clock;
// there is no derived clock.
//
// Optional feature: define CHECKSUM_VERIFY_EN to compare the last byte of the
// frame against the 8-bit sum of all preceding bytes. Without it every
// complete frame is accepted.
//
// Ports
//   clk   system clock
//   rst   asynchronous, active-high reset (releases the bus immediately)
//   dht   reader side of dht_sensor_reader_param_if (start/result/bus pins)
// ---------------------------------------------------------------------------
module dht_sensor_reader_param #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int NUM_BITS      = 40,
    parameter int START_LOW_US  = 19000,
    parameter int RELEASE_US    = 20,
    parameter int BIT_THRESH_US = 50,
    parameter int TIMEOUT_US    = 65000,
    parameter int GUARD_US      = 2000,
    parameter int MAX_RETRIES   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    dht_sensor_reader_param_if.slave  dht
);

    localparam int TICK_DIV  = CLK_FREQ_HZ / 1_000_000;
    localparam int DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W     = $clog2(NUM_BITS + 1);
    localparam int NUM_BYTES = NUM_BITS / 8;

    localparam logic [16:0] US_START   = 17'(START_LOW_US);
    localparam logic [16:0] US_RELEASE = 17'(RELEASE_US);
    localparam logic [16:0] US_THRESH  = 17'(BIT_THRESH_US);
    localparam logic [16:0] US_TIMEOUT = 17'(TIMEOUT_US);
    localparam logic [16:0] US_GUARD   = 17'(GUARD_US);

    // Attempts run 1..MAX_RETRIES+1. Testing "not yet at the last attempt"
    // by inequality keeps the loop bounded even when MAX_RETRIES+1 wraps the
    // 3-bit counter (MAX_RETRIES = 7).
    localparam logic [2:0] LAST_ATTEMPT = 3'(MAX_RETRIES + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_RELEASE,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_RESP_END,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_FAIL,
        S_GUARD,
        S_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [DIV_W-1:0]    div_reg;
    logic                tick;
    logic [1:0]          sync_reg;
    logic                bus_level;
    logic [16:0]         us_reg;
    logic                timeout;
    logic [NUM_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic                last_bit;
    logic [2:0]          attempt_reg;
    logic                error_reg;
    logic [1:0]          error_code_reg;
    logic [NUM_BITS-1:0] data_reg;
    logic                check_pass;

    logic drive_low_reg, busy_reg, done_reg;
    logic drive_low_next, busy_next, done_next;

    // -----------------------------------------------------------------------
    // 1 us tick: free-running divider, one-cycle enable per wrap.
    // -----------------------------------------------------------------------
    assign tick = (div_reg == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Bus synchroniser. Reset to the idle (pulled-up) level so the first
    // cycles after reset never look like a sensor response.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], dht.sensor_in};
        end
    end

    assign bus_level = sync_reg[1];

    // -----------------------------------------------------------------------
    // Microsecond counter: measures time spent in the current state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_reg <= '0;
        end else if (state_next != state_reg) begin
            us_reg <= '0;
        end else if (tick) begin
            us_reg <= us_reg + 17'd1;
        end
    end

    assign timeout  = (us_reg == US_TIMEOUT);
    assign last_bit = (bit_cnt_reg == CNT_W'(NUM_BITS - 1));

    // -----------------------------------------------------------------------
    // Frame check
    // -----------------------------------------------------------------------
`ifdef CHECKSUM_VERIFY_EN
    // Running 8-bit sum over the payload bytes, first received byte first.
    logic [7:0] psum [NUM_BYTES-1];

    generate
        for (genvar gi = 0; gi < NUM_BYTES - 1; gi++) begin : g_sum
            if (gi == 0) begin : g_first
                assign psum[gi] = shift_reg[NUM_BITS-1 -: 8];
            end else begin : g_rest
                assign psum[gi] = psum[gi-1] + shift_reg[NUM_BITS-1-8*gi -: 8];
            end
        end
    endgenerate

    assign check_pass = (psum[NUM_BYTES-2] == shift_reg[7:0]);
`else
    assign check_pass = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. A bus edge takes priority over a timeout
    // that expires in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (dht.start)              state_next = S_START_LOW;
            S_START_LOW: if (us_reg == US_START)     state_next = S_RELEASE;
            S_RELEASE:   if (us_reg == US_RELEASE)   state_next = S_RESP_LOW;
            S_RESP_LOW:  if (!bus_level)             state_next = S_RESP_HIGH;
                         else if (timeout)           state_next = S_FAIL;
            S_RESP_HIGH: if (bus_level)              state_next = S_RESP_END;
                         else if (timeout)           state_next = S_FAIL;
            S_RESP_END:  if (!bus_level)             state_next = S_BIT_LOW;
                         else if (timeout)           state_next = S_FAIL;
            S_BIT_LOW:   if (bus_level)              state_next = S_BIT_HIGH;
                         else if (timeout)           state_next = S_FAIL;
            S_BIT_HIGH:  if (!bus_level)             state_next = last_bit ? S_CHECK : S_BIT_LOW;
                         else if (timeout)           state_next = S_FAIL;
            S_CHECK:     state_next = check_pass ? S_DONE : S_FAIL;
            S_FAIL:      state_next = (attempt_reg != LAST_ATTEMPT) ? S_GUARD : S_DONE;
            S_GUARD:     if (us_reg == US_GUARD)     state_next = S_START_LOW;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output decode. Decoded from the next state and registered so the
    // pad control never glitches while the state vector changes.
    // -----------------------------------------------------------------------
    always_comb begin
        drive_low_next = (state_next == S_START_LOW);
        busy_next      = !(state_next inside {S_IDLE, S_DONE});
        done_next      = (state_next == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drive_low_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            drive_low_reg <= drive_low_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: shift register, bit count, attempts and result registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            attempt_reg    <= '0;
            error_reg      <= 1'b0;
            error_code_reg <= 2'd0;
            data_reg       <= '0;
        end else begin
            if (state_reg == S_IDLE && dht.start) begin
                attempt_reg    <= 3'd1;
                error_reg      <= 1'b0;
                error_code_reg <= 2'd0;
            end

            // Each attempt starts with an empty frame.
            if (state_reg != S_START_LOW && state_next == S_START_LOW) begin
                shift_reg   <= '0;
                bit_cnt_reg <= '0;
            end

            if (state_reg == S_GUARD && state_next == S_START_LOW) begin
                attempt_reg <= attempt_reg + 3'd1;
            end

            // Falling edge ends the high phase; its length decides the bit.
            if (state_reg == S_BIT_HIGH && !bus_level) begin
                shift_reg   <= {shift_reg[NUM_BITS-2:0], (us_reg > US_THRESH)};
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end

            if (state_next == S_FAIL) begin
                case (state_reg)
                    S_RESP_LOW, S_RESP_HIGH: error_code_reg <= 2'd1;
                    S_CHECK:                 error_code_reg <= 2'd3;
                    default:                 error_code_reg <= 2'd2;
                endcase
            end

            // Success clears any code left over from earlier attempts.
            if (state_reg == S_CHECK && check_pass) begin
                data_reg       <= shift_reg;
                error_reg      <= 1'b0;
                error_code_reg <= 2'd0;
            end

            if (state_reg == S_FAIL && state_next == S_DONE) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign dht.sensor_drive_low = drive_low_reg;
    assign dht.busy             = busy_reg;
    assign dht.done             = done_reg;
    assign dht.error            = error_reg;
    assign dht.error_code       = error_code_reg;
    assign dht.attempts         = attempt_reg;
    assign dht.data             = data_reg;

endmodule

// File: tb/tb_dht_sensor_reader_param.sv
`timescale 1ns/1ps
module tb_dht_sensor_reader_param;

    localparam int NB        = 40;
    localparam int CLK_HZ    = 2_000_000;   // 2 clocks per microsecond
    localparam int START_US  = 200;
    localparam int REL_US    = 20;
    localparam int THRESH_US = 50;
    localparam int TMO_US    = 300;
    localparam int GUARD_US  = 100;
    localparam int RETRIES   = 2;
    localparam int US_NS     = 1000;
    localparam int BUDGET    = 40000;

    typedef struct packed {
        logic          err;
        logic [1:0]    code;
        logic [2:0]    att;
        logic [NB-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic model_low = 1'b0;

    dht_sensor_reader_param_if #(.NUM_BITS(NB)) dht ();

    dht_sensor_reader_param #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .NUM_BITS     (NB),
        .START_LOW_US (START_US),
        .RELEASE_US   (REL_US),
        .BIT_THRESH_US(THRESH_US),
        .TIMEOUT_US   (TMO_US),
        .GUARD_US     (GUARD_US),
        .MAX_RETRIES  (RETRIES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dht(dht)
    );

    always #250 clk = ~clk;

    // Open-drain bus with pull-up: low if either side pulls it.
    assign dht.sensor_in = !(dht.sensor_drive_low || model_low);

    int tests = 0;
    int fails = 0;
    int done_count = 0;
    int pushed = 0;
    exp_t exp_q[$];

    logic [NB-1:0] model_frame = '0;
    bit sensor_present = 1'b0;
    int stop_after = 0;

    int pulse_count = 0;
    int last_width = 0;
    int last_gap = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        tests++;
        if (v < lo || v > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    // ---------------- DHT11 sensor model ----------------
    initial begin
        int sent;
        forever begin
            @(posedge dht.sensor_drive_low);
            @(negedge dht.sensor_drive_low);
            if (sensor_present && !rst) begin
                #(30*US_NS);
                model_low = 1'b1; #(80*US_NS);
                model_low = 1'b0; #(80*US_NS);
                sent = (stop_after > 0) ? stop_after : NB;
                for (int i = 0; i < sent; i++) begin
                    model_low = 1'b1; #(50*US_NS);
                    model_low = 1'b0;
                    if (model_frame[NB-1-i]) #(70*US_NS);
                    else                     #(26*US_NS);
                end
                if (sent == NB) begin
                    model_low = 1'b1; #(50*US_NS);
                    model_low = 1'b0;
                end
                stop_after = 0;
            end
        end
    end

    // ---------------- start-pulse monitor ----------------
    initial begin
        logic prev;
        int hi_cnt, lo_cnt;
        prev = 1'b0; hi_cnt = 0; lo_cnt = 0;
        forever begin
            @(negedge clk);
            if (dht.sensor_drive_low) begin
                if (!prev) begin
                    pulse_count++;
                    last_gap = lo_cnt;
                    hi_cnt = 0;
                end
                hi_cnt++;
            end else begin
                if (prev) begin
                    last_width = hi_cnt;
                    lo_cnt = 0;
                end
                lo_cnt++;
            end
            prev = dht.sensor_drive_low;
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && dht.done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done #%0d, expected none", done_count);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] done #%0d: error=%0d code=%0d attempts=%0d data=0x%010h", done_count,
                             dht.error, dht.error_code, dht.attempts, dht.data);
                    check("done_error",    64'(dht.error),      64'(e.err));
                    check("done_code",     64'(dht.error_code), 64'(e.code));
                    check("done_attempts", 64'(dht.attempts),   64'(e.att));
                    check("done_data",     64'(dht.data),       64'(e.data));
                    check("done_busy_low", 64'(dht.busy),       64'd0);
                end
            end
        end
    end

    task automatic push_exp(input logic err, input logic [1:0] code, input logic [2:0] att,
                            input logic [NB-1:0] data);
        exp_t e;
        e.err = err; e.code = code; e.att = att; e.data = data;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic start_txn();
        @(negedge clk); dht.start = 1'b1;
        @(negedge clk); dht.start = 1'b0;
    endtask

    task automatic wait_pulse(input int n);
        int k;
        for (k = 0; k < BUDGET; k++) begin
            @(posedge clk);
            if (pulse_count >= n) break;
        end
        if (k == BUDGET) begin
            tests++; fails++;
            $display("FAIL wait_pulse: got %0d pulses, expected %0d", pulse_count, n);
        end
    endtask

    // Waits for done; optionally raises start in the done cycle itself.
    task automatic wait_done(input bit poke);
        int k;
        for (k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (dht.done) break;
        end
        if (k == BUDGET) begin
            tests++; fails++;
            $display("FAIL wait_done: got no done within %0d cycles, expected done", BUDGET);
        end
        if (poke) begin
            dht.start = 1'b1;
            @(negedge clk);
            dht.start = 1'b0;
        end
        repeat (200) @(negedge clk);   // let the sensor finish its trailing low
    endtask

    localparam logic [NB-1:0] FRAME_A = 40'h23_00_19_00_3C;
    localparam logic [NB-1:0] FRAME_B = 40'h0A_0B_0C_0D_2E;
    localparam logic [NB-1:0] FRAME_C = 40'h23_00_19_00_3D;

    initial begin
        logic [NB-1:0] last_good;
        int base;
        dht.start = 1'b0;
        last_good = '0;

        // ---- reset state ----
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_drive",    64'(dht.sensor_drive_low), 64'd0);
        check("rst_busy",     64'(dht.busy),             64'd0);
        check("rst_done",     64'(dht.done),             64'd0);
        check("rst_error",    64'(dht.error),            64'd0);
        check("rst_code",     64'(dht.error_code),       64'd0);
        check("rst_attempts", 64'(dht.attempts),         64'd0);
        check("rst_data",     64'(dht.data),             64'd0);

        // ---- 1: good DHT11 frame, one attempt ----
        sensor_present = 1'b1; model_frame = FRAME_A; stop_after = 0;
        push_exp(1'b0, 2'd0, 3'd1, FRAME_A);
        base = pulse_count;
        start_txn();
        @(negedge clk);
        check("t1_busy", 64'(dht.busy), 64'd1);
        wait_done(1'b0);
        last_good = FRAME_A;
        check_range("t1_start_width", last_width, 2*START_US - 3, 2*START_US + 4);
        check("t1_pulses", 64'(pulse_count - base), 64'd1);

        // ---- 2: no sensor, all retries used ----
        sensor_present = 1'b0;
        push_exp(1'b1, 2'd1, 3'd3, last_good);
        base = pulse_count;
        start_txn();
        wait_pulse(base + 2);
        @(negedge clk);
        check_range("t2_gap1", last_gap, 2*(REL_US + TMO_US + GUARD_US) - 2,
                    2*(REL_US + TMO_US + GUARD_US) + 8);
        check("t2_mid_code",     64'(dht.error_code), 64'd1);
        check("t2_mid_error",    64'(dht.error),      64'd0);
        check("t2_mid_attempts", 64'(dht.attempts),   64'd2);
        wait_pulse(base + 3);
        @(negedge clk);
        check_range("t2_gap2", last_gap, 2*(REL_US + TMO_US + GUARD_US) - 2,
                    2*(REL_US + TMO_US + GUARD_US) + 8);
        wait_done(1'b0);
        check("t2_pulses",     64'(pulse_count - base), 64'd3);
        check("t2_error_held", 64'(dht.error),          64'd1);

        // ---- 3: sensor stops after bit 17, then a good frame ----
        sensor_present = 1'b1; model_frame = FRAME_B; stop_after = 17;
        push_exp(1'b0, 2'd0, 3'd2, FRAME_B);
        base = pulse_count;
        start_txn();
        check("t3_error_cleared", 64'(dht.error), 64'd0);
        wait_pulse(base + 2);
        @(negedge clk);
        check("t3_mid_code", 64'(dht.error_code), 64'd2);
        wait_done(1'b0);
        last_good = FRAME_B;

        // ---- 4: frame with a bad checksum byte ----
        sensor_present = 1'b1; model_frame = FRAME_C; stop_after = 0;
`ifdef CHECKSUM_VERIFY_EN
        push_exp(1'b1, 2'd3, 3'd3, last_good);
`else
        push_exp(1'b0, 2'd0, 3'd1, FRAME_C);
        last_good = FRAME_C;
`endif
        start_txn();
        wait_done(1'b0);

        // ---- 5: reset part-way through the start pulse ----
        sensor_present = 1'b0;
        base = pulse_count;
        start_txn();
        wait_pulse(base + 1);
        repeat (200) @(negedge clk);
        check("t5_drive_before", 64'(dht.sensor_drive_low), 64'd1);
        #60 rst = 1'b1;
        #1;
        check("t5_drive_async", 64'(dht.sensor_drive_low), 64'd0);
        check("t5_busy_async",  64'(dht.busy),             64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_error",    64'(dht.error),      64'd0);
        check("t5_code",     64'(dht.error_code), 64'd0);
        check("t5_attempts", 64'(dht.attempts),   64'd0);
        check("t5_data",     64'(dht.data),       64'd0);
        repeat (20) @(negedge clk);
        check("t5_idle_busy", 64'(dht.busy), 64'd0);

        // ---- 6: full pulse after reset; starts while busy and at done ignored ----
        sensor_present = 1'b1; model_frame = FRAME_A; stop_after = 0;
        push_exp(1'b0, 2'd0, 3'd1, FRAME_A);
        base = pulse_count;
        start_txn();
        for (int k = 0; k < 4; k++) begin
            repeat (300) @(negedge clk);
            dht.start = 1'b1;
            @(negedge clk);
            dht.start = 1'b0;
        end
        wait_done(1'b1);
        check_range("t6_start_width", last_width, 2*START_US - 3, 2*START_US + 4);
        check("t6_pulses",    64'(pulse_count - base), 64'd1);
        check("t6_idle_busy", 64'(dht.busy),           64'd0);

        // ---- scoreboard bookkeeping ----
        check("done_count",  64'(done_count),   64'(pushed));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
